score_cmd_arbiter: RTL

Two-requester command arbiter and sequencer for the scoreboard's BCD score counter. It sits between the requesters (the pushbutton conditioner and an auxiliary or remote command port) and the counter's incr/decr/clr strobes. It grants one command at a time with round-robin fairness and clear priority. It spaces strobes by a programmable gap and optionally filters commands that would push the score past 00 or 99.

---
 rtl/score_cmd_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/score_cmd_arbiter.sv
// Two-requester round-robin command arbiter/sequencer for the BCD score counter.
// Optional saturation filter enabled by defining SCORE_SAT_FILTER_EN.
module score_cmd_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int SIMULATE   = 0
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_cmd0,
  input  logic [1:0] req_cmd1,
  output logic [1:0] req_ack,
  input  logic [7:0] score_bcd,
  output logic       cmd_incr,
  output logic       cmd_decr,
  output logic       cmd_clr,
  output logic       cmd_drop,
  output logic       busy
);

  localparam logic [1:0] CMD_INC = 2'b00;
  localparam logic [1:0] CMD_DEC = 2'b01;
  localparam logic [1:0] CMD_CLR = 2'b10;
  localparam logic [1:0] CMD_RSV = 2'b11;
  localparam logic [7:0] GAP_EFF = (SIMULATE != 0) ? 8'd1 : 8'(GAP_CYCLES);

`ifdef SCORE_SAT_FILTER_EN
  localparam bit SAT_FILTER = 1'b1;
`else
  localparam bit SAT_FILTER = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t     state_q, state_d;
  logic [7:0] gap_q, gap_d;
  logic       last_q, last_d;
  logic       win_q, win_d;
  logic [1:0] cmd_q, cmd_d;
  logic       sat_q, sat_d;
  logic [1:0] ack_q, ack_d;
  logic       incr_q, incr_d;
  logic       decr_q, decr_d;
  logic       clr_q, clr_d;
  logic       drop_q, drop_d;
  logic       busy_q, busy_d;

  logic       clr0, clr1, pick;
  logic [1:0] sel_cmd;
  logic       sat_hit;

  // clr outranks incr/decr; otherwise the requester not granted last wins
  always_comb begin
    clr0 = req_valid[0] && (req_cmd0 == CMD_CLR);
    clr1 = req_valid[1] && (req_cmd1 == CMD_CLR);
    if (req_valid == 2'b01)      pick = 1'b0;
    else if (req_valid == 2'b10) pick = 1'b1;
    else if (clr0 != clr1)       pick = clr1;
    else                         pick = ~last_q;
  end

  assign sel_cmd = pick ? req_cmd1 : req_cmd0;
  assign sat_hit = SAT_FILTER &&
                   (((sel_cmd == CMD_INC) && (score_bcd == 8'h99)) ||
                    ((sel_cmd == CMD_DEC) && (score_bcd == 8'h00)));

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gap_q   <= 8'd0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      cmd_q   <= CMD_INC;
      sat_q   <= 1'b0;
      ack_q   <= 2'b00;
      incr_q  <= 1'b0;
      decr_q  <= 1'b0;
      clr_q   <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
      sat_q   <= sat_d;
      ack_q   <= ack_d;
      incr_q  <= incr_d;
      decr_q  <= decr_d;
      clr_q   <= clr_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    last_d  = last_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d = S_ISSUE;
          win_d   = pick;
          last_d  = pick;
          cmd_d   = sel_cmd;
          sat_d   = sat_hit;
        end
      end
      S_ISSUE: begin
        state_d = S_HOLD;
        gap_d   = GAP_EFF;
      end
      S_HOLD: begin
        if (gap_q != 8'd0) gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d  = 2'b00;
    incr_d = 1'b0;
    decr_d = 1'b0;
    clr_d  = 1'b0;
    drop_d = 1'b0;
    busy_d = (state_q != S_IDLE);
    if (state_q == S_ISSUE) begin
      ack_d = win_q ? 2'b10 : 2'b01;
      if (sat_q || (cmd_q == CMD_RSV)) begin
        drop_d = 1'b1;
      end else begin
        case (cmd_q)
          CMD_INC: incr_d = 1'b1;
          CMD_DEC: decr_d = 1'b1;
          default: clr_d  = 1'b1;
        endcase
      end
    end
  end

  assign req_ack  = ack_q;
  assign cmd_incr = incr_q;
  assign cmd_decr = decr_q;
  assign cmd_clr  = clr_q;
  assign cmd_drop = drop_q;
  assign busy     = busy_q;

endmodule
